// File: rtl/ysyx_22041461_shift_seq_if.sv
// Request/response bus between the EXU and the iterative shift sequencer.
// The EXU side is master; the sequencer side is slave.
interface ysyx_22041461_shift_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [63:0] in_src1;
   logic [63:0] in_src2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;

   modport master (
      output in_valid, in_op, in_src1, in_src2, flush, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_op, in_src1, in_src2, flush, out_ready,
      output in_ready, out_valid, out_result
   );
endinterface

// File: rtl/ysyx_22041461_shift_seq.sv
// Iterative SLL/SRL/SRA (+W) shifter moving 2**STEP_LOG2 bits per cycle.
// Define SHIFT_SEQ_FAST_EN to finish single-step shifts on the accept edge.
module ysyx_22041461_shift_seq #(
   parameter int unsigned STEP_LOG2 = 3
) (
   input logic                     clk,
   input logic                     rst,
   ysyx_22041461_shift_seq_if.slave bus
);
   localparam logic [5:0] STEP_AMT = 6'(32'd1 << STEP_LOG2);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_next;
   logic [63:0] work;
   logic [5:0]  remaining;
   logic [2:0]  op;
   logic [63:0] result;

   logic        acc_w, acc_legal, acc_fast, acc_direct, accept, last_step;
   logic [5:0]  acc_shamt, step_d;
   logic [63:0] acc_work, step_work;
`ifdef SHIFT_SEQ_FAST_EN
   logic [63:0] acc_fast_work;
`endif

   // kind: 00 logical left, 01 logical right, 10 arithmetic right
   function automatic logic [63:0] shift_by(input logic [63:0] v, input logic [1:0] kind,
                                            input logic [5:0] d);
      case (kind)
         2'b00:   return v << d;
         2'b01:   return v >> d;
         default: return 64'($signed(v) >>> d);
      endcase
   endfunction

   function automatic logic [63:0] fmt(input logic [63:0] v, input logic w);
      return w ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

   always_comb begin
      acc_w     = bus.in_op[2];
      acc_legal = (bus.in_op[1:0] != 2'b11);
      acc_shamt = acc_w ? {1'b0, bus.in_src2[4:0]} : bus.in_src2[5:0];
      acc_work  = bus.in_src1;
      if (acc_w)
         acc_work = (bus.in_op[1:0] == 2'b10) ? {{32{bus.in_src1[31]}}, bus.in_src1[31:0]}
                                               : {32'd0, bus.in_src1[31:0]};
`ifdef SHIFT_SEQ_FAST_EN
      acc_fast      = (acc_shamt <= STEP_AMT);
      acc_fast_work = shift_by(acc_work, bus.in_op[1:0], acc_shamt);
`else
      acc_fast      = 1'b0;
`endif
      acc_direct = !acc_legal || (acc_shamt == 6'd0) || acc_fast;
      accept     = (state == IDLE) && bus.in_valid && !bus.flush;
      step_d     = (remaining > STEP_AMT) ? STEP_AMT : remaining;
      step_work  = shift_by(work, op[1:0], step_d);
      last_step  = (remaining <= STEP_AMT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = acc_direct ? DONE : SHIFT;
         SHIFT:   if (bus.flush) state_next = IDLE;
                  else if (last_step) state_next = DONE;
         DONE:    if (bus.flush || bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready   = (state == IDLE);
      bus.out_valid  = (state == DONE);
      bus.out_result = result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work      <= '0;
         remaining <= '0;
         op        <= '0;
         result    <= '0;
      end else if (accept) begin
         op        <= bus.in_op;
         work      <= acc_work;
         remaining <= acc_shamt;
         // Illegal ops ignore shamt entirely; zero shamt skips SHIFT.
         if (!acc_legal) begin
            result <= '0;
         end else if (acc_shamt == 6'd0) begin
            result <= fmt(acc_work, acc_w);
`ifdef SHIFT_SEQ_FAST_EN
         end else if (acc_fast) begin
            work      <= acc_fast_work;
            remaining <= '0;
            result    <= fmt(acc_fast_work, acc_w);
`endif
         end
      end else if (state == SHIFT && !bus.flush) begin
         work      <= step_work;
         remaining <= remaining - step_d;
         if (last_step) result <= fmt(step_work, op[2]);
      end
   end
endmodule

// File: tb/tb_ysyx_22041461_shift_seq.sv
// Directed + random checks of the shift sequencer against a plain-arithmetic model.
// Honors SHIFT_SEQ_FAST_EN for expected latency.
module tb_ysyx_22041461_shift_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned tests = 0;
   int unsigned fails = 0;

   ysyx_22041461_shift_seq_if bus ();

   ysyx_22041461_shift_seq #(.STEP_LOG2(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [63:0] a,
                                              input logic [63:0] b);
      logic [31:0] r32;
      case (o)
         3'b000: return a << b[5:0];
         3'b001: return a >> b[5:0];
         3'b010: return 64'($signed(a) >>> b[5:0]);
         3'b100: begin r32 = a[31:0] << b[4:0]; return {{32{r32[31]}}, r32}; end
         3'b101: begin r32 = a[31:0] >> b[4:0]; return {{32{r32[31]}}, r32}; end
         3'b110: begin r32 = 32'($signed(a[31:0]) >>> b[4:0]); return {{32{r32[31]}}, r32}; end
         default: return 64'd0;
      endcase
   endfunction

   // Edges after the accept edge until out_valid is seen.
   function automatic int unsigned ref_latency(input logic [2:0] o, input logic [63:0] b);
      int unsigned sh;
      if (o[1:0] == 2'b11) return 0;
      sh = o[2] ? int'(b[4:0]) : int'(b[5:0]);
      if (sh == 0) return 0;
`ifdef SHIFT_SEQ_FAST_EN
      if (sh <= 8) return 0;
`endif
      return (sh + 7) / 8;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input int unsigned hold);
      logic [63:0] exp;
      int unsigned lat, cyc;
      exp = ref_result(o, a, b);
      lat = ref_latency(o, b);
      bus.out_ready = (hold == 0);
      bus.in_op     = o;
      bus.in_src1   = a;
      bus.in_src2   = b;
      bus.in_valid  = 1'b1;
      chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "/latency"}, 64'(cyc), 64'(lat));
      chk({tag, "/result"}, bus.out_result, exp);
      for (int unsigned h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.in_op    = 3'b000;
         bus.in_src2  = 64'd0;
         @(posedge clk); #1;
         chk({tag, "/hold_valid"}, 64'(bus.out_valid), 64'd1);
         chk({tag, "/hold_result"}, bus.out_result, exp);
         chk({tag, "/hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "/idle_in_ready"}, 64'(bus.in_ready), 64'd1);
      chk({tag, "/idle_out_valid"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      logic [2:0]  ops [8];
      logic [2:0]  o;
      logic [63:0] a, b;
      logic        seen;
      ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b011, 3'b111};

      bus.in_valid  = 1'b0;
      bus.in_op     = 3'b000;
      bus.in_src1   = 64'd0;
      bus.in_src2   = 64'd0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("reset/in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset/out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset/out_result", bus.out_result, 64'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      run_op("srl63", 3'b001, 64'h8000_0000_0000_0000, 64'd63, 0);
      run_op("sraw4", 3'b110, 64'h0000_0000_8000_0000, 64'd4, 0);
      run_op("sllw31", 3'b100, 64'd1, 64'h3F, 0);
      run_op("sll0", 3'b000, 64'd1, 64'd0, 0);
      run_op("backpressure", 3'b010, 64'h8123_4567_89AB_CDEF, 64'd20, 5);

      // Flush in the third SHIFT cycle of a 63-bit shift.
      bus.in_op = 3'b001; bus.in_src1 = 64'h8000_0000_0000_0000; bus.in_src2 = 64'd63;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_shift/in_ready", 64'(bus.in_ready), 64'd1);
      seen = bus.out_valid;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         seen = seen | bus.out_valid;
      end
      chk("flush_shift/no_valid", 64'(seen), 64'd0);
      run_op("sra4_after_flush", 3'b010, 64'hF000_0000_0000_0000, 64'd4, 0);

      // Flush in IDLE with a request pending blocks the accept.
      bus.in_op = 3'b000; bus.in_src1 = 64'd5; bus.in_src2 = 64'd0;
      bus.in_valid = 1'b1; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      chk("flush_idle/in_ready", 64'(bus.in_ready), 64'd1);
      chk("flush_idle/out_valid", 64'(bus.out_valid), 64'd0);

      // Flush in DONE wins over a held result.
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("flush_done/valid_before", 64'(bus.out_valid), 64'd1);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      chk("flush_done/out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_done/in_ready", 64'(bus.in_ready), 64'd1);

      run_op("sll_nonzero", 3'b000, 64'h0000_0000_0000_00FF, 64'd8, 0);

      // Asynchronous reset between edges during SHIFT.
      bus.in_op = 3'b001; bus.in_src1 = 64'h8000_0000_0000_0000; bus.in_src2 = 64'd63;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("async_rst/in_ready", 64'(bus.in_ready), 64'd1);
      chk("async_rst/out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst/out_result", bus.out_result, 64'd0);
      #2 rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         seen = seen | bus.out_valid;
      end
      chk("async_rst/no_valid", 64'(seen), 64'd0);

      run_op("illegal011", 3'b011, 64'hDEAD_BEEF_DEAD_BEEF, 64'd17, 0);
      run_op("illegal111", 3'b111, 64'h1234_5678_9ABC_DEF0, 64'd3, 0);
      run_op("srlw_neg", 3'b101, 64'hFFFF_FFFF_8000_0000, 64'd31, 0);
      run_op("sll8", 3'b000, 64'h1, 64'd8, 0);
      run_op("sll9", 3'b000, 64'h1, 64'd9, 0);

      for (int i = 0; i < 40; i++) begin
         o = ops[$urandom_range(0, 7)];
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) b = b & 64'hF;
         run_op("random", o, a, b, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
